rc4_phase_ctrl: RTL and testbench
=================================

RC4_PHASE_CTRL -- requirements
Module: rc4_phase_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, S-memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, S-memory data width.
REQ-003 SHALL have parameter TIMEOUT, default 4096, maximum cycles any phase may run before an error is raised.
REQ-004 SHALL have ports: clk in 1 clock; rst_n in 1, reset is asynchronous and active-low.
REQ-005 SHALL have ports: start in 1, one-cycle run request; busy out 1; done out 1; error out 1; phase out 2, current phase (0 idle, 1 fill, 2 ksa, 3 decrypt).
REQ-006 SHALL have, per engine X in {fill, ksa, dec}: X_start out 1; X_finish in 1; X_addr in ADDR_W; X_wdata in DATA_W; X_wren in 1.
REQ-007 SHALL have memory ports: s_addr out ADDR_W; s_wdata out DATA_W; s_wren out 1.

Function
REQ-008 SHALL implement FSM states IDLE, FILL_GO, FILL_WAIT, KSA_GO, KSA_WAIT, DEC_GO, DEC_WAIT, DONE, ERROR.
REQ-009 SHALL move from IDLE, DONE or ERROR to FILL_GO on the edge where start=1; start in any other state is ignored.
REQ-010 SHALL assert X_start high for exactly the one cycle spent in X_GO, then enter X_WAIT.
REQ-011 SHALL ignore X_finish while in X_GO (stale level from a previous run).
REQ-012 SHALL leave X_WAIT on the first edge with X_finish=1: FILL_WAIT->KSA_GO, KSA_WAIT->DEC_GO, DEC_WAIT->DONE.
REQ-013 SHALL grant the S-memory only to the engine whose phase is current (GO or WAIT state): s_addr/s_wdata/s_wren pass through combinationally from that engine.
REQ-014 SHALL drive s_wren=0, s_addr=0, s_wdata=0 in IDLE, DONE and ERROR; writes from engines that do not hold the grant are dropped.
REQ-015 SHALL count cycles in each X_WAIT, clearing the count on entry; if the count reaches TIMEOUT-1 with X_finish=0, SHALL enter ERROR on the next edge.
REQ-016 SHALL treat X_finish=1 on the same edge as the timeout terminal count as success (finish wins).
REQ-017 SHALL drive busy=1 in all GO/WAIT states, done=1 only in DONE, error=1 only in ERROR; done and error hold until the next accepted start.
REQ-018 SHALL register all outputs except the memory mux (REQ-013); start-to-fill_start latency is exactly 1 cycle.
REQ-019 SHALL restart cleanly from DONE or ERROR, clearing done/error on the edge that accepts start.

Reset
REQ-020 SHALL on rst_n=0 immediately force IDLE, busy=0, done=0, error=0, phase=0, all X_start=0, timeout count=0, memory outputs per REQ-014.
REQ-021 SHALL abort any phase in progress when reset asserts mid-run; no X_start is issued until a new start after reset release.

Structure
REQ-022 SHALL place the FSM state enum, phase encoding and default ADDR_W/DATA_W constants in shared package rc4_pkg.
REQ-023 SHALL implement the timeout counter as sub-module rc4_watchdog (inputs clear, enable; output expired at TIMEOUT-1).

Verification
REQ-024 Normal run: start pulse; fill_finish 256 cycles after fill_start, ksa 768, dec 64 -> fill_start/ksa_start/dec_start each one cycle, done=1, phase sequence 0,1,2,3,0.
REQ-025 Grant isolation: during fill phase, ksa_wren=1 with ksa_addr=8'h55 -> s_wren follows fill_wren only; address 8'h55 never seen on s_addr.
REQ-026 Timeout: TIMEOUT=16, ksa_finish held 0 -> error=1 exactly 16 cycles after KSA_WAIT entry, busy=0, s_wren=0.
REQ-027 Boundary: fill_finish=1 on the terminal-count cycle -> ksa_start next, error stays 0; fill_finish already high during FILL_GO -> not accepted until FILL_WAIT.
REQ-028 Reset mid-run: rst_n low during DEC_WAIT -> busy/done/error=0 immediately; subsequent start runs full sequence from fill.
REQ-029 Busy start: start pulses during KSA_WAIT -> ignored, no extra fill_start, run completes with done=1.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 phase sequencer.
// Holds the FSM state encoding, the phase encoding and the default S-memory widths.
package rc4_pkg;

    localparam int unsigned RC4_ADDR_W = 8;
    localparam int unsigned RC4_DATA_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FILL_GO,
        ST_FILL_WAIT,
        ST_KSA_GO,
        ST_KSA_WAIT,
        ST_DEC_GO,
        ST_DEC_WAIT,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_FILL = 2'd1,
        PH_KSA  = 2'd2,
        PH_DEC  = 2'd3
    } phase_t;

    // IDLE, DONE and ERROR all report phase 0 and hold no memory grant.
    function automatic phase_t phase_of(input state_t s);
        case (s)
            ST_FILL_GO, ST_FILL_WAIT: phase_of = PH_FILL;
            ST_KSA_GO,  ST_KSA_WAIT:  phase_of = PH_KSA;
            ST_DEC_GO,  ST_DEC_WAIT:  phase_of = PH_DEC;
            default:                  phase_of = PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rc4_watchdog.sv
// Per-phase cycle counter; expired is raised while enabled at count TIMEOUT-1.
// The count saturates at the terminal value so a stalled phase cannot wrap.
module rc4_watchdog #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TERM)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == TERM);

endmodule

// File: rtl/rc4_phase_ctrl.sv
// Sequences the fill, KSA and decrypt engines and arbitrates the shared S-memory.
// Status and start strobes are registered; only the memory mux is combinational.
module rc4_phase_ctrl
    import rc4_pkg::*;
#(
    parameter int unsigned ADDR_W  = RC4_ADDR_W,
    parameter int unsigned DATA_W  = RC4_DATA_W,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        phase,

    output logic              fill_start,
    input  logic              fill_finish,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_wdata,
    input  logic              fill_wren,

    output logic              ksa_start,
    input  logic              ksa_finish,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [DATA_W-1:0] ksa_wdata,
    input  logic              ksa_wren,

    output logic              dec_start,
    input  logic              dec_finish,
    input  logic [ADDR_W-1:0] dec_addr,
    input  logic [DATA_W-1:0] dec_wdata,
    input  logic              dec_wren,

    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_wren
);

    state_t state_q;
    state_t state_d;
    phase_t phase_q;
    logic   wd_clear;
    logic   wd_enable;
    logic   expired;

    rc4_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (expired)
    );

    // Finish is tested before expiry so a finish on the terminal-count edge wins.
    always_comb begin
        state_d   = state_q;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) state_d = ST_FILL_GO;
            end
            ST_FILL_GO: begin
                wd_clear = 1'b1;
                state_d  = ST_FILL_WAIT;
            end
            ST_FILL_WAIT: begin
                wd_enable = 1'b1;
                if (fill_finish)  state_d = ST_KSA_GO;
                else if (expired) state_d = ST_ERROR;
            end
            ST_KSA_GO: begin
                wd_clear = 1'b1;
                state_d  = ST_KSA_WAIT;
            end
            ST_KSA_WAIT: begin
                wd_enable = 1'b1;
                if (ksa_finish)   state_d = ST_DEC_GO;
                else if (expired) state_d = ST_ERROR;
            end
            ST_DEC_GO: begin
                wd_clear = 1'b1;
                state_d  = ST_DEC_WAIT;
            end
            ST_DEC_WAIT: begin
                wd_enable = 1'b1;
                if (dec_finish)   state_d = ST_DONE;
                else if (expired) state_d = ST_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            fill_start <= 1'b0;
            ksa_start  <= 1'b0;
            dec_start  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_of(state_d);
            busy       <= (phase_of(state_d) != PH_IDLE);
            done       <= (state_d == ST_DONE);
            error      <= (state_d == ST_ERROR);
            fill_start <= (state_d == ST_FILL_GO);
            ksa_start  <= (state_d == ST_KSA_GO);
            dec_start  <= (state_d == ST_DEC_GO);
        end
    end

    assign phase = phase_q;

    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wren  = 1'b0;
        case (phase_q)
            PH_FILL: begin
                s_addr  = fill_addr;
                s_wdata = fill_wdata;
                s_wren  = fill_wren;
            end
            PH_KSA: begin
                s_addr  = ksa_addr;
                s_wdata = ksa_wdata;
                s_wren  = ksa_wren;
            end
            PH_DEC: begin
                s_addr  = dec_addr;
                s_wdata = dec_wdata;
                s_wren  = dec_wren;
            end
            default: begin
                s_addr  = '0;
                s_wdata = '0;
                s_wren  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rc4_phase_ctrl.sv
// Directed bench for rc4_phase_ctrl: one default instance for full runs,
// one with TIMEOUT=16 for watchdog and terminal-count boundaries.
module tb_rc4_phase_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, start_b;
    logic [2:0] fins_a, fins_b;

    logic [7:0] fill_addr, fill_wdata, ksa_addr, ksa_wdata, dec_addr, dec_wdata;
    logic       fill_wren, ksa_wren, dec_wren;

    logic       busy_a, done_a, error_a, fill_start_a, ksa_start_a, dec_start_a, s_wren_a;
    logic [1:0] phase_a_o;
    logic [7:0] s_addr_a, s_wdata_a;
    logic [2:0] starts_a;

    logic       busy_b, done_b, error_b, fill_start_b, ksa_start_b, dec_start_b, s_wren_b;
    logic [1:0] phase_b_o;
    logic [7:0] s_addr_b, s_wdata_b;

    assign starts_a = {dec_start_a, ksa_start_a, fill_start_a};

    rc4_phase_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .busy(busy_a), .done(done_a), .error(error_a), .phase(phase_a_o),
        .fill_start(fill_start_a), .fill_finish(fins_a[0]),
        .fill_addr(fill_addr), .fill_wdata(fill_wdata), .fill_wren(fill_wren),
        .ksa_start(ksa_start_a), .ksa_finish(fins_a[1]),
        .ksa_addr(ksa_addr), .ksa_wdata(ksa_wdata), .ksa_wren(ksa_wren),
        .dec_start(dec_start_a), .dec_finish(fins_a[2]),
        .dec_addr(dec_addr), .dec_wdata(dec_wdata), .dec_wren(dec_wren),
        .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_wren(s_wren_a)
    );

    rc4_phase_ctrl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .busy(busy_b), .done(done_b), .error(error_b), .phase(phase_b_o),
        .fill_start(fill_start_b), .fill_finish(fins_b[0]),
        .fill_addr(fill_addr), .fill_wdata(fill_wdata), .fill_wren(fill_wren),
        .ksa_start(ksa_start_b), .ksa_finish(fins_b[1]),
        .ksa_addr(ksa_addr), .ksa_wdata(ksa_wdata), .ksa_wren(ksa_wren),
        .dec_start(dec_start_b), .dec_finish(fins_b[2]),
        .dec_addr(dec_addr), .dec_wdata(dec_wdata), .dec_wren(dec_wren),
        .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_wren(s_wren_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_fill = 0;
    int n_ksa = 0;
    int n_dec = 0;

    // Counts start-strobe samples of instance A.
    always @(negedge clk) begin
        n_fill <= n_fill + int'(fill_start_a);
        n_ksa  <= n_ksa + int'(ksa_start_a);
        n_dec  <= n_dec + int'(dec_start_a);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Entered on the negedge where starts_a[e] is first visible.
    task automatic phase_a(input int e, input int len, input bit gtest, input bit bpulse);
        int bad_ph, bad_gnt, seen55;
        bad_ph = 0; bad_gnt = 0; seen55 = 0;
        check_eq("x_start", 32'(starts_a[e]), 1);
        check_eq("x_phase_go", 32'(phase_a_o), e + 1);
        for (int i = 1; i < len; i++) begin
            if (gtest) begin
                fill_addr  = 8'(2 * i);
                fill_wdata = 8'(i);
                fill_wren  = i[0];
                #1;
                if (s_wren_a !== fill_wren || s_addr_a !== fill_addr || s_wdata_a !== fill_wdata)
                    bad_gnt++;
                if (s_addr_a == 8'h55) seen55++;
            end
            if (bpulse) start_a = (i == 3) || (i == 6);
            @(negedge clk);
            if (phase_a_o != 2'(e + 1) || starts_a != 3'b000) bad_ph++;
        end
        start_a = 1'b0;
        fins_a[e] = 1'b1;
        @(negedge clk);
        fins_a[e] = 1'b0;
        check_eq("x_wait_stable", bad_ph, 0);
        if (gtest) begin
            check_eq("grant_mux", bad_gnt, 0);
            check_eq("grant_no_55", seen55, 0);
        end
    endtask

    task automatic run_a(input int lf, input int lk, input int ld, input bit gtest, input bit bpulse);
        int f0, k0, d0;
        f0 = n_fill; k0 = n_ksa; d0 = n_dec;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check_eq("accept_done_clr", done_a, 0);
        check_eq("accept_err_clr", error_a, 0);
        check_eq("accept_busy", busy_a, 1);
        phase_a(0, lf, gtest, 1'b0);
        phase_a(1, lk, 1'b0, bpulse);
        phase_a(2, ld, 1'b0, 1'b0);
        check_eq("done_set", done_a, 1);
        check_eq("done_busy", busy_a, 0);
        check_eq("done_err", error_a, 0);
        check_eq("done_phase", phase_a_o, 0);
        check_eq("done_s_wren", s_wren_a, 0);
        check_eq("done_s_addr", s_addr_a, 0);
        repeat (2) @(negedge clk);
        check_eq("done_hold", done_a, 1);
        check_eq("fill_start_cnt", n_fill - f0, 1);
        check_eq("ksa_start_cnt", n_ksa - k0, 1);
        check_eq("dec_start_cnt", n_dec - d0, 1);
    endtask

    initial begin
        int f0, d0;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; fins_a = '0; fins_b = '0;
        fill_addr = '0; fill_wdata = '0; fill_wren = 1'b0;
        ksa_addr = 8'h55; ksa_wdata = 8'hAA; ksa_wren = 1'b1;
        dec_addr = 8'h3C; dec_wdata = 8'hC3; dec_wren = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_error", error_a, 0);
        check_eq("rst_phase", phase_a_o, 0);
        check_eq("rst_starts", starts_a, 0);
        check_eq("rst_s_wren", s_wren_a, 0);
        check_eq("rst_s_addr", s_addr_a, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_no_start", n_fill, 0);

        // Normal run with grant isolation during fill.
        run_a(256, 768, 64, 1'b1, 1'b0);

        // Restart from DONE with start pulses during KSA_WAIT.
        run_a(8, 12, 4, 1'b0, 1'b1);

        // Stale fill_finish during FILL_GO, then KSA timeout on the 16-cycle instance.
        fins_b[0] = 1'b1; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check_eq("b_fill_start", fill_start_b, 1);
        @(negedge clk);
        check_eq("b_stale_phase", phase_b_o, 1);
        check_eq("b_stale_ksa", ksa_start_b, 0);
        @(negedge clk);
        fins_b[0] = 1'b0;
        check_eq("b_ksa_start", ksa_start_b, 1);
        check_eq("b_ksa_phase", phase_b_o, 2);
        repeat (16) @(negedge clk);
        check_eq("b_pre_to_err", error_b, 0);
        check_eq("b_pre_to_busy", busy_b, 1);
        check_eq("b_pre_to_wren", s_wren_b, 1);
        @(negedge clk);
        check_eq("b_to_err", error_b, 1);
        check_eq("b_to_busy", busy_b, 0);
        check_eq("b_to_wren", s_wren_b, 0);
        check_eq("b_to_phase", phase_b_o, 0);
        check_eq("b_to_done", done_b, 0);
        repeat (2) @(negedge clk);
        check_eq("b_err_hold", error_b, 1);

        // Restart from ERROR; fill_finish on the terminal-count cycle must win.
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check_eq("b_err_clr", error_b, 0);
        check_eq("b_fill_start2", fill_start_b, 1);
        repeat (16) @(negedge clk);
        check_eq("b_tc_still_fill", phase_b_o, 1);
        fins_b[0] = 1'b1;
        @(negedge clk);
        fins_b[0] = 1'b0;
        check_eq("b_tc_ksa_start", ksa_start_b, 1);
        check_eq("b_tc_no_err", error_b, 0);
        @(negedge clk);
        fins_b[1] = 1'b1;
        @(negedge clk);
        fins_b[1] = 1'b0;
        check_eq("b_dec_start", dec_start_b, 1);
        @(negedge clk);
        fins_b[2] = 1'b1;
        @(negedge clk);
        fins_b[2] = 1'b0;
        check_eq("b_done", done_b, 1);
        check_eq("b_done_err", error_b, 0);

        // Reset asserted in DEC_WAIT on instance A.
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        phase_a(0, 4, 1'b0, 1'b0);
        phase_a(1, 4, 1'b0, 1'b0);
        check_eq("mr_dec_start", dec_start_a, 1);
        repeat (3) @(negedge clk);
        check_eq("mr_busy", busy_a, 1);
        check_eq("mr_dec_grant", s_addr_a, 8'h3C);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mr_rst_busy", busy_a, 0);
        check_eq("mr_rst_done", done_a, 0);
        check_eq("mr_rst_err", error_a, 0);
        check_eq("mr_rst_phase", phase_a_o, 0);
        check_eq("mr_rst_wren", s_wren_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        f0 = n_fill; d0 = n_dec;
        repeat (5) @(negedge clk);
        check_eq("mr_no_fill", n_fill - f0, 0);
        check_eq("mr_no_dec", n_dec - d0, 0);
        check_eq("mr_idle_phase", phase_a_o, 0);
        run_a(4, 4, 4, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
